// File: rtl/conv_frame_writer_if.sv
// Stream-in / RAM-write-port bundle for conv_frame_writer.
//  master: frame controller + pixel source side (drives start, base_addr, in_valid, in_pixel)
//  slave : the writer itself (drives mem_we/mem_addr/mem_wdata, busy, frame_done, err_drop)
// Signals:
//  start, base_addr      arm one frame at the given frame-buffer base address
//  in_valid, in_pixel    convolution output stream, no backpressure
//  mem_we/addr/wdata     frame-buffer RAM write port
//  busy, frame_done      frame status towards the controller
//  err_drop              sticky flag: a pixel arrived outside a frame and was discarded
interface conv_frame_writer_if #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ADDR_W    = 19
);
  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic                 in_valid;
  logic [WORD_SIZE-1:0] in_pixel;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic                 busy;
  logic                 frame_done;
  logic                 err_drop;

  modport master (
    output start, base_addr, in_valid, in_pixel,
    input  mem_we, mem_addr, mem_wdata, busy, frame_done, err_drop
  );

  modport slave (
    input  start, base_addr, in_valid, in_pixel,
    output mem_we, mem_addr, mem_wdata, busy, frame_done, err_drop
  );
endinterface

// File: rtl/conv_frame_writer.sv
// Convolution output sink: writes each valid pixel of a frame, in raster order, to the
// frame-buffer RAM at base + y*OUT_W + x, where OUT_W x OUT_H is the valid-convolution size.
// Ports:
//  clk   clock, all logic on posedge
//  rst   synchronous, active-high reset
//  bus   conv_frame_writer_if slave modport (stream in, RAM write port, frame status)
// The address is a running counter seeded with base_addr, so no multiplier is needed; it wraps
// modulo 2^ADDR_W. All outputs are registered.
module conv_frame_writer #(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned ROW_SIZE   = 540,
  parameter int unsigned ROW_COUNT  = 540,
  parameter int unsigned KERNEL_DIM = 3,
  parameter int unsigned ADDR_W     = 19
) (
  input logic                clk,
  input logic                rst,
  conv_frame_writer_if.slave bus
);

  localparam int unsigned OUT_W = ROW_SIZE - KERNEL_DIM + 1;
  localparam int unsigned OUT_H = ROW_COUNT - KERNEL_DIM + 1;
  localparam int unsigned XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [XW-1:0] XLast = XW'(OUT_W - 1);
  localparam logic [YW-1:0] YLast = YW'(OUT_H - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= StIdle;
      x              <= '0;
      y              <= '0;
      addr           <= '0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_drop   <= 1'b0;
    end else begin
      // Strobes default low; address/data hold their last values.
      bus.mem_we     <= 1'b0;
      bus.frame_done <= 1'b0;

      unique case (state)
        StIdle: begin
          if (bus.start) begin
            // Clearing wins over a pixel dropped in the same cycle.
            state        <= StRun;
            addr         <= bus.base_addr;
            x            <= '0;
            y            <= '0;
            bus.busy     <= 1'b1;
            bus.err_drop <= 1'b0;
          end else if (bus.in_valid) begin
            bus.err_drop <= 1'b1;
          end
        end

        StRun: begin
          if (bus.in_valid) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= addr;
            bus.mem_wdata <= bus.in_pixel;
            addr          <= addr + 1'b1;
            if (x == XLast) begin
              x <= '0;
              if (y == YLast) begin
                // frame_done lands in the DONE cycle, alongside the final write strobe.
                y              <= '0;
                state          <= StDone;
                bus.frame_done <= 1'b1;
              end else begin
                y <= y + 1'b1;
              end
            end else begin
              x <= x + 1'b1;
            end
          end
        end

        StDone: begin
          state    <= StIdle;
          bus.busy <= 1'b0;
          if (bus.in_valid) begin
            bus.err_drop <= 1'b1;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule
